// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//
// Shared definitions for the multiplexed 7-segment scan controller.
//
// Segment encoding: bit 0..6 = segments a..g, active-low (a 0 lights the
// segment). The display is common-anode, so "all ones" means fully dark.
//
// Contents:
//   nibble_t      - one hex digit value
//   seg_t         - one 7-bit active-low segment pattern
//   SEG_0..SEG_F  - glyphs for hex 0..F ('b' and 'd' are lowercase so they
//                   cannot be confused with '8' and '0')
//   SEG_OFF       - all segments dark
//   hex_to_seg()  - nibble -> glyph lookup
//
// Configuration macro used by importers: SEG_PWM_EN (see seg_scan_ctrl).
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    //                              gfedcba
    localparam seg_t SEG_0   = 7'b1000000;
    localparam seg_t SEG_1   = 7'b1111001;
    localparam seg_t SEG_2   = 7'b0100100;
    localparam seg_t SEG_3   = 7'b0110000;
    localparam seg_t SEG_4   = 7'b0011001;
    localparam seg_t SEG_5   = 7'b0010010;
    localparam seg_t SEG_6   = 7'b0000010;
    localparam seg_t SEG_7   = 7'b1111000;
    localparam seg_t SEG_8   = 7'b0000000;
    localparam seg_t SEG_9   = 7'b0010000;
    localparam seg_t SEG_A   = 7'b0001000;
    localparam seg_t SEG_B   = 7'b0000011;  // lowercase b
    localparam seg_t SEG_C   = 7'b1000110;
    localparam seg_t SEG_D   = 7'b0100001;  // lowercase d
    localparam seg_t SEG_E   = 7'b0000110;
    localparam seg_t SEG_F   = 7'b0001110;

    localparam seg_t SEG_OFF = 7'h7F;

    // Glyph lookup. Every nibble value has an entry, so the default arm is
    // only there to keep the case statement obviously complete.
    function automatic seg_t hex_to_seg(input nibble_t nib);
        seg_t glyph;
        case (nib)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            4'hF:    glyph = SEG_F;
            default: glyph = SEG_OFF;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// ---------------------------------------------------------------------------
// seg_decoder
//
// Purely combinational hex nibble -> active-low 7-segment glyph decode.
// A single instance sits on the already-multiplexed digit nibble, so only
// one decoder is needed regardless of how many digits are scanned.
//
// Ports:
//   nibble  in  4  hex value to show
//   seg     out 7  segments a..g = bit 0..6, active-low
// ---------------------------------------------------------------------------
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Scan controller for a multiplexed common-anode 7-segment display.
// DIGITS hex digits share one segment bus; each digit owns a slot of 2^DIV
// clock cycles. The first BLANK_CYC cycles of every slot keep all digit
// selects off so the previous digit's pattern cannot ghost onto the next.
// New digit values arrive on a valid/ready port, wait in a pending buffer,
// and are copied to the display registers only at a frame boundary, so a
// frame is never drawn with a mix of old and new values.
//
// Configuration:
//   SEG_PWM_EN  defined   -> a digit is additionally gated by
//                            slot_cnt[DIV-1 -: PWM_BITS] <= brightness
//               undefined -> no brightness gating; the brightness port is
//                            kept for pin compatibility but ignored
//
// Parameters:
//   DIGITS     number of digits (2..8)
//   DIV        log2 of clock cycles per digit slot
//   BLANK_CYC  dark cycles at the start of each slot (< 2^DIV)
//   PWM_BITS   brightness resolution (<= DIV)
//
// Ports:
//   clk          in   1           system clock
//   rst          in   1           synchronous active-high reset
//   wr_valid     in   1           write request
//   wr_ready     out  1           pending buffer empty
//   wr_data      in   4*DIGITS    hex nibbles, [3:0] = digit 0 (rightmost)
//   wr_dp        in   DIGITS      decimal points, bit i = digit i
//   brightness   in   PWM_BITS    global duty level
//   seg          out  7           segments a..g, active-low
//   dp           out  1           decimal point, active-low
//   sel          out  DIGITS      digit enables, active-low, at most one low
//   frame_start  out  1           one-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIV       = 16,
    parameter int BLANK_CYC = 64,
    parameter int PWM_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // -----------------------------------------------------------------------
    // Scan counters
    // -----------------------------------------------------------------------
    logic [DIV-1:0]   slot_cnt_reg;
    logic [IDX_W-1:0] digit_idx_reg;
    logic             slot_wrap;
    logic             last_digit;
    logic             frame_end;

    assign slot_wrap  = &slot_cnt_reg;
    assign last_digit = (digit_idx_reg == IDX_W'(DIGITS - 1));
    assign frame_end  = slot_wrap & last_digit;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_reg  <= '0;
            digit_idx_reg <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + 1'b1;
            if (slot_wrap) begin
                digit_idx_reg <= last_digit ? '0 : digit_idx_reg + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write path: pending buffer -> display registers at frame boundary
    // -----------------------------------------------------------------------
    logic [4*DIGITS-1:0] pend_data_reg;
    logic [DIGITS-1:0]   pend_dp_reg;
    logic                pending_full_reg;
    logic [4*DIGITS-1:0] disp_data_reg;
    logic [DIGITS-1:0]   disp_dp_reg;
    logic                wr_accept;

    assign wr_ready  = ~pending_full_reg;
    assign wr_accept = wr_valid & ~pending_full_reg;

    // A write can only be accepted while the buffer is empty, and a commit
    // only happens while it is full, so the two branches below never fire
    // in the same cycle. That is also why a write taken in the boundary
    // cycle itself waits a whole frame for the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data_reg    <= '0;
            pend_dp_reg      <= '0;
            pending_full_reg <= 1'b0;
            disp_data_reg    <= '0;
            disp_dp_reg      <= '0;
        end else begin
            if (frame_end && pending_full_reg) begin
                disp_data_reg    <= pend_data_reg;
                disp_dp_reg      <= pend_dp_reg;
                pending_full_reg <= 1'b0;
            end
            if (wr_accept) begin
                pend_data_reg    <= wr_data;
                pend_dp_reg      <= wr_dp;
                pending_full_reg <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Blanking and brightness gating
    // -----------------------------------------------------------------------
    logic blank_done;
    logic pwm_ok;
    logic digit_on;

    assign blank_done = (slot_cnt_reg >= DIV'(BLANK_CYC));

`ifdef SEG_PWM_EN
    // The top PWM_BITS of the slot counter form a ramp across the slot;
    // the digit stays lit while the ramp is at or below the duty level.
    assign pwm_ok = (slot_cnt_reg[DIV-1 -: PWM_BITS] <= brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_ok            = 1'b1;
`endif

    assign digit_on = blank_done & pwm_ok;

    // -----------------------------------------------------------------------
    // Digit multiplexing and decode
    // -----------------------------------------------------------------------
    logic [3:0]        nib_arr [DIGITS];
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic [6:0]        dec_seg;
    logic [DIGITS-1:0] sel_next;
    logic [6:0]        seg_next;
    logic              dp_next;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib_arr[gi] = disp_data_reg[4*gi +: 4];
    end

    assign cur_nib = nib_arr[digit_idx_reg];
    assign cur_dp  = disp_dp_reg[digit_idx_reg];

    seg_decoder u_seg_decoder (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // One select per digit; only the scanned digit can go low, and only
    // while the gating allows it, so at most one bit is ever low.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
        assign sel_next[gi] = ~(digit_on && (digit_idx_reg == IDX_W'(gi)));
    end

    // Segments are forced dark whenever no digit is selected so the bus
    // never carries a stale pattern into the next slot.
    assign seg_next = digit_on ? dec_seg : SEG_OFF;
    assign dp_next  = digit_on ? ~cur_dp : 1'b1;

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic [6:0]        seg_reg;
    logic              dp_reg;
    logic [DIGITS-1:0] sel_reg;
    logic              frame_start_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg         <= SEG_OFF;
            dp_reg          <= 1'b1;
            sel_reg         <= '1;
            frame_start_reg <= 1'b0;
        end else begin
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            sel_reg         <= sel_next;
            frame_start_reg <= frame_end;
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign sel         = sel_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl (DIGITS=4, DIV=6, BLANK_CYC=4,
// PWM_BITS=4). A reference model tracks time since reset as a plain cycle
// count and derives slot/digit position arithmetically, holding the pending
// and displayed values as simple arrays. Every cycle the registered outputs
// are compared with the model; directed checks cover the reset state, the
// first frame pulse, glyph values, boundary-cycle writes, duty cycle and
// mid-handshake reset. Honours SEG_PWM_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int DIV       = 6;
    localparam int BLANK_CYC = 4;
    localparam int PWM_BITS  = 4;
    localparam int SLOT      = 1 << DIV;
    localparam int FRAME     = DIGITS * SLOT;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_valid;
    logic                wr_ready;
    logic [4*DIGITS-1:0] wr_data;
    logic [DIGITS-1:0]   wr_dp;
    logic [PWM_BITS-1:0] brightness;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   sel;
    logic                frame_start;

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC),
        .PWM_BITS  (PWM_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .sel         (sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Hex glyph table, gfedcba active-low.
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s : got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         mt;              // clock edges since reset release
    logic [3:0] m_disp  [DIGITS];
    logic [3:0] m_pend  [DIGITS];
    logic       m_disp_dp [DIGITS];
    logic       m_pend_dp [DIGITS];
    bit         m_full;
    logic [6:0]        e_seg;
    logic              e_dp;
    logic [DIGITS-1:0] e_sel;
    logic              e_fs;
    logic              e_ready;

    function automatic bit duty_ok(int s, int b);
`ifdef SEG_PWM_EN
        return (s / (1 << (DIV - PWM_BITS))) <= b;
`else
        return 1'b1;
`endif
    endfunction

    // Evaluated at each rising edge with the inputs seen by that edge.
    task automatic model_edge();
        int pos, d, s;
        bit on, boundary;
        if (rst) begin
            mt = 0;
            m_full = 0;
            for (int i = 0; i < DIGITS; i++) begin
                m_disp[i] = 0; m_pend[i] = 0; m_disp_dp[i] = 0; m_pend_dp[i] = 0;
            end
            e_seg = 7'h7F; e_dp = 1; e_sel = '1; e_fs = 0; e_ready = 1;
            return;
        end
        pos      = mt % FRAME;
        d        = pos / SLOT;
        s        = pos % SLOT;
        on       = (s >= BLANK_CYC) && duty_ok(s, int'(brightness));
        boundary = (pos == FRAME - 1);
        e_sel = '1;
        if (on) e_sel[d] = 1'b0;
        e_seg = on ? glyph[m_disp[d]] : 7'h7F;
        e_dp  = on ? ~m_disp_dp[d] : 1'b1;
        e_fs  = boundary;
        if (boundary && m_full) begin
            for (int i = 0; i < DIGITS; i++) begin
                m_disp[i] = m_pend[i]; m_disp_dp[i] = m_pend_dp[i];
            end
            m_full = 0;
        end else if (wr_valid && !m_full) begin
            for (int i = 0; i < DIGITS; i++) begin
                m_pend[i] = wr_data[4*i +: 4]; m_pend_dp[i] = wr_dp[i];
            end
            m_full = 1;
        end
        e_ready = !m_full;
        mt++;
    endtask

    bit first_fs_seen = 0;
    int first_fs_at   = -1;
    bit early_phase   = 1;

    // One clock: model update at the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("sel", sel, e_sel);
        check_val("seg", seg, e_seg);
        check_val("dp", dp, e_dp);
        check_val("frame_start", frame_start, e_fs);
        check_val("wr_ready", wr_ready, e_ready);
        check_val("sel_onehot", ($countones(~sel) <= 1), 1);
        if (early_phase) begin
            if (mt == 4) check_val("slot0_blank_c4", sel, 4'hF);
            if (mt == 5) check_val("slot0_on_c5", sel, 4'b1110);
            if (frame_start && !first_fs_seen) begin
                first_fs_seen = 1;
                first_fs_at   = mt;
            end
        end
    endtask

    logic [6:0] cap_seg [DIGITS];
    logic       cap_dp  [DIGITS];
    int         cnt;
    int         on_cnt;
    int         nbad_disp;

    initial begin
        rst = 1; wr_valid = 0; wr_data = '0; wr_dp = '0; brightness = 4'hF;
        repeat (3) step();
        check_val("rst_sel", sel, 4'hF);
        check_val("rst_seg", seg, 7'h7F);
        check_val("rst_ready", wr_ready, 1);
        rst = 0;

        // Free-run into the second frame; first pulse expected at 256.
        repeat (300) step();
        check_val("first_frame_start", first_fs_at, 256);
        early_phase = 0;

        // Mid-frame write of 8F01, dp on digit 2.
        wr_valid = 1; wr_data = 16'h8F01; wr_dp = 4'b0100;
        step();
        wr_valid = 0;
        check_val("ready_low_after_wr", wr_ready, 0);
        cnt = 0;
        while (!wr_ready && cnt < 2 * FRAME) begin step(); cnt++; end
        check_val("commit_timeout", (cnt < 2 * FRAME), 1);
        for (int i = 0; i < DIGITS; i++) begin cap_seg[i] = 7'h7F; cap_dp[i] = 1; end
        repeat (FRAME) begin
            step();
            for (int i = 0; i < DIGITS; i++)
                if (!sel[i]) begin cap_seg[i] = seg; cap_dp[i] = dp; end
        end
        check_val("dig0_seg", cap_seg[0], 7'b1111001);
        check_val("dig1_seg", cap_seg[1], 7'b1000000);
        check_val("dig2_seg", cap_seg[2], 7'b0001110);
        check_val("dig2_dp", cap_dp[2], 0);
        check_val("dig3_seg", cap_seg[3], 7'b0000000);
        check_val("dig0_dp", cap_dp[0], 1);

        // Write presented exactly in the boundary cycle.
        cnt = 0;
        while (mt % FRAME != FRAME - 1 && cnt < 2 * FRAME) begin step(); cnt++; end
        wr_valid = 1; wr_data = 16'h3C7A; wr_dp = 4'b1001;
        step();
        wr_valid = 0;
        check_val("bnd_ready_low", wr_ready, 0);
        cnt = 0;
        while (!wr_ready && cnt < 3 * FRAME) begin step(); cnt++; end
        check_val("bnd_hold_cycles", cnt, FRAME);

        // Randomised traffic and brightness.
        repeat (2500) begin
            wr_valid   = ($urandom_range(0, 39) == 0);
            wr_data    = 16'($urandom);
            wr_dp      = 4'($urandom);
            brightness = 4'($urandom);
            step();
        end
        wr_valid = 0;

        // Duty cycle: on-cycles over one full frame (4 slots).
        brightness = 4'hF; on_cnt = 0;
        repeat (FRAME) begin step(); if (sel != 4'hF) on_cnt++; end
        check_val("duty_F", on_cnt, 4 * 60);
        brightness = 4'h0; on_cnt = 0;
        repeat (FRAME) begin step(); if (sel != 4'hF) on_cnt++; end
`ifdef SEG_PWM_EN
        check_val("duty_0", on_cnt, 0);
`else
        check_val("duty_0", on_cnt, 4 * 60);
`endif
        brightness = 4'h3; on_cnt = 0;
        repeat (FRAME) begin step(); if (sel != 4'hF) on_cnt++; end
`ifdef SEG_PWM_EN
        check_val("duty_3", on_cnt, 4 * 12);
`else
        check_val("duty_3", on_cnt, 4 * 60);
`endif

        // Reset during a pending write.
        brightness = 4'hF;
        cnt = 0;
        while (!wr_ready && cnt < 2 * FRAME) begin step(); cnt++; end
        wr_valid = 1; wr_data = 16'hA5C3; wr_dp = 4'hF;
        step();
        wr_valid = 0;
        repeat (10) step();
        rst = 1;
        step();
        check_val("midrst_ready", wr_ready, 1);
        check_val("midrst_sel", sel, 4'hF);
        check_val("midrst_seg", seg, 7'h7F);
        rst = 0;
        nbad_disp = 0;
        repeat (2 * FRAME + 10) begin
            step();
            if (sel != 4'hF && (seg != 7'b1000000 || dp != 1'b1)) nbad_disp++;
        end
        check_val("midrst_all_zero", nbad_disp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
